// File: rtl/aes_128_key_expand.sv
// rtl/aes_128_key_expand.sv - iterative AES-128 key schedule feeding the round-key RAM
//
// Expands a 128-bit cipher key into the 11 FIPS-197 round keys, one round at a time.
// Each round key is written as two 64-bit halves (upper first), and key_ready is then raised.
// SubWord uses an external 32-bit S-box port with one-cycle read latency.
//
// Ports:
//   clk           in   1   clock, rising edge
//   kill          in   1   asynchronous active-high reset
//   key_start     in   1   start pulse; key_in is sampled in the same cycle
//   key_in        in 128   cipher key, [127:96] = w0
//   sbox_addr     out 32   RotWord(w3) of the key register, four S-box byte addresses
//   sbox_data     in  32   S-box result for the previous cycle's sbox_addr
//   en_wr         out  1   round-key RAM write strobe
//   key_round_wr  out 64   half round key being written
//   key_ready     out  1   all 22 halves have been written
//   busy          out  1   expansion in progress

module aes_128_key_expand (
    input  logic         clk,
    input  logic         kill,
    input  logic         key_start,
    input  logic [127:0] key_in,
    output logic [31:0]  sbox_addr,
    input  logic [31:0]  sbox_data,
    output logic         en_wr,
    output logic [63:0]  key_round_wr,
    output logic         key_ready,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_HI = 3'd1,
        WR_LO = 3'd2,
        SUB   = 3'd3,
        CALC  = 3'd4
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   round_q, round_d;
    logic         ready_q, ready_d;

    logic [31:0]  w3;
    logic [31:0]  t;
    logic [31:0]  w0_n, w1_n, w2_n, w3_n;

    assign w3 = key_q[31:0];

    // Byte rotation feeds the S-box lanes; only meaningful while in SUB.
    assign sbox_addr = {w3[23:0], w3[31:24]};

    // The S-box answer arrives in CALC, one cycle after the address was shown in SUB.
    assign t    = sbox_data ^ {rcon_q, 24'h000000};
    assign w0_n = key_q[127:96] ^ t;
    assign w1_n = key_q[95:64]  ^ w0_n;
    assign w2_n = key_q[63:32]  ^ w1_n;
    assign w3_n = w3            ^ w2_n;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rcon_d  = rcon_q;
        round_d = round_q;
        ready_d = ready_q;
        case (state_q)
            IDLE: begin
                if (key_start) begin
                    key_d   = key_in;
                    rcon_d  = 8'h01;
                    round_d = 4'd0;
                    ready_d = 1'b0;
                    state_d = WR_HI;
                end
            end
            WR_HI: state_d = WR_LO;
            WR_LO: begin
                if (round_q == 4'd10) begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = SUB;
                end
            end
            SUB: state_d = CALC;
            CALC: begin
                key_d   = {w0_n, w1_n, w2_n, w3_n};
                round_d = round_q + 4'd1;
                // xtime in GF(2^8): 80 wraps to 1B, giving the 1B,36 tail of the sequence.
                rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                state_d = WR_HI;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge kill) begin
        if (kill) begin
            state_q <= IDLE;
            key_q   <= 128'h0;
            rcon_q  <= 8'h00;
            round_q <= 4'd0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rcon_q  <= rcon_d;
            round_q <= round_d;
            ready_q <= ready_d;
        end
    end

    assign en_wr        = (state_q == WR_HI) || (state_q == WR_LO);
    assign key_round_wr = (state_q == WR_HI) ? key_q[127:64] :
                          (state_q == WR_LO) ? key_q[63:0]   : 64'h0;
    assign key_ready    = ready_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_aes_128_key_expand.sv
// tb/tb_aes_128_key_expand.sv - directed self-checking bench for aes_128_key_expand

module tb_aes_128_key_expand;

    logic         clk;
    logic         kill;
    logic         key_start;
    logic [127:0] key_in;
    logic [31:0]  sbox_addr;
    logic [31:0]  sbox_data;
    logic         en_wr;
    logic [63:0]  key_round_wr;
    logic         key_ready;
    logic         busy;

    int total = 0;
    int bad   = 0;

    logic [7:0]  sb [256];
    logic [63:0] wr_q [$];
    logic [63:0] fips [22];

    aes_128_key_expand dut (
        .clk          (clk),
        .kill         (kill),
        .key_start    (key_start),
        .key_in       (key_in),
        .sbox_addr    (sbox_addr),
        .sbox_data    (sbox_data),
        .en_wr        (en_wr),
        .key_round_wr (key_round_wr),
        .key_ready    (key_ready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // S-box model with one-cycle read latency.
    always @(posedge clk)
        sbox_data <= {sb[sbox_addr[31:24]], sb[sbox_addr[23:16]],
                      sb[sbox_addr[15:8]],  sb[sbox_addr[7:0]]};

    always @(negedge clk)
        if (en_wr === 1'b1) wr_q.push_back(key_round_wr);

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] s;
        inv = 8'h00;
        for (int b = 1; b < 256; b++)
            if (gmul(a, b[7:0]) == 8'h01) inv = b[7:0];
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
            {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts an expansion from a negedge and follows it for 43 cycles, checking the
    // strobe pattern, busy and key_ready each cycle. Optionally fires a second start
    // pulse with another key during cycle alt_cycle.
    task automatic run(input logic [127:0] k, input int alt_cycle, input logic [127:0] alt_key,
                       output int ready_cyc);
        wr_q.delete();
        key_in    = k;
        key_start = 1'b1;
        @(posedge clk);
        #1 key_start = 1'b0;
        ready_cyc = -1;
        for (int c = 1; c <= 43; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("c1_key_ready_low", {127'h0, key_ready}, 128'h0);
                check("c1_wr_hi", {64'h0, key_round_wr}, {64'h0, k[127:64]});
            end
            check($sformatf("en_wr_c%0d", c), {127'h0, en_wr},
                  {127'h0, (c <= 42) && ((c % 4 == 1) || (c % 4 == 2))});
            check($sformatf("busy_c%0d", c), {127'h0, busy}, {127'h0, (c < 43)});
            if (key_ready === 1'b1 && ready_cyc < 0) ready_cyc = c;
            if (c == alt_cycle) begin
                key_in    = alt_key;
                key_start = 1'b1;
                @(posedge clk);
                #1 key_start = 1'b0;
            end
        end
    endtask

    task automatic check_fips_stream(input string tag);
        check({tag, "_count"}, wr_q.size(), 22);
        for (int i = 0; i < 22; i++)
            if (i < wr_q.size())
                check($sformatf("%s_w%0d", tag, i + 1), {64'h0, wr_q[i]}, {64'h0, fips[i]});
    endtask

    int rc;

    initial begin
        fips = '{64'h2b7e151628aed2a6, 64'habf7158809cf4f3c,
                 64'ha0fafe1788542cb1, 64'h23a339392a6c7605,
                 64'hf2c295f27a96b943, 64'h5935807a7359f67f,
                 64'h3d80477d4716fe3e, 64'h1e237e446d7a883b,
                 64'hef44a541a8525b7f, 64'hb671253bdb0bad00,
                 64'hd4d1c6f87c839d87, 64'hcaf2b8bc11f915bc,
                 64'h6d88a37a110b3efd, 64'hdbf98641ca0093fd,
                 64'h4e54f70e5f5fc9f3, 64'h84a64fb24ea6dc4f,
                 64'head27321b58dbad2, 64'h312bf5607f8d292f,
                 64'hac7766f319fadc21, 64'h28d12941575c006e,
                 64'hd014f9a8c9ee2589, 64'he13f0cc8b6630ca6};
        for (int i = 0; i < 256; i++) sb[i] = sbox_f(i[7:0]);

        kill      = 1'b1;
        key_start = 1'b0;
        key_in    = 128'h0;
        repeat (2) @(negedge clk);
        check("rst_en_wr", {127'h0, en_wr}, 128'h0);
        check("rst_key_round_wr", {64'h0, key_round_wr}, 128'h0);
        check("rst_key_ready", {127'h0, key_ready}, 128'h0);
        check("rst_busy", {127'h0, busy}, 128'h0);
        check("rst_sbox_addr", {96'h0, sbox_addr}, 128'h0);
        kill = 1'b0;
        @(negedge clk);

        // FIPS-197 key
        run(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 128'h0, rc);
        check("fips_ready_cycle", rc, 43);
        check_fips_stream("fips");

        // Back-to-back: all-zero key started in the first key_ready cycle
        run(128'h0, 0, 128'h0, rc);
        check("zero_ready_cycle", rc, 43);
        check("zero_count", wr_q.size(), 22);
        if (wr_q.size() == 22) begin
            check("zero_round1", {wr_q[2], wr_q[3]}, 128'h62636363626363636263636362636363);
            check("zero_round10", {wr_q[20], wr_q[21]}, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        end

        // Start while busy is ignored
        run(128'h2b7e151628aed2a6abf7158809cf4f3c, 10, 128'hffeeddccbbaa99887766554433221100, rc);
        check("busy_start_ready_cycle", rc, 43);
        check_fips_stream("busy_start");

        // Kill during cycle 20
        wr_q.delete();
        key_in    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        key_start = 1'b1;
        @(posedge clk);
        #1 key_start = 1'b0;
        repeat (20) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        check("kill_en_wr", {127'h0, en_wr}, 128'h0);
        check("kill_busy", {127'h0, busy}, 128'h0);
        check("kill_key_ready", {127'h0, key_ready}, 128'h0);
        check("kill_sbox_addr", {96'h0, sbox_addr}, 128'h0);
        check("kill_write_count", wr_q.size(), 10);

        // Kill release coincides with the restart pulse
        kill = 1'b0;
        run(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 128'h0, rc);
        check("restart_ready_cycle", rc, 43);
        check_fips_stream("restart");
        if (wr_q.size() == 22) begin
            check("rcon_1b_round9", {wr_q[18], wr_q[19]}, 128'hac7766f319fadc2128d12941575c006e);
            check("rcon_36_round10", {wr_q[20], wr_q[21]}, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        end

        // No stray writes once idle
        repeat (8) @(negedge clk);
        check("idle_no_extra_writes", wr_q.size(), 22);
        check("idle_key_ready_held", {127'h0, key_ready}, {127'h0, 1'b1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
